// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/load-store memory arbiter.
// Imported by mem_arbiter and arb_grant.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      RESP
   } mem_arb_state_t;

   typedef enum logic {
      OWNER_I,
      OWNER_D
   } mem_arb_owner_t;

   // Bit positions inside the one-hot grant vector
   localparam int GRANT_I = 0;
   localparam int GRANT_D = 1;

   function automatic mem_arb_owner_t other_owner(input mem_arb_owner_t owner);
      return (owner == OWNER_I) ? OWNER_D : OWNER_I;
   endfunction

endpackage

// File: rtl/mem_arbiter_grant.sv
// arb_grant: combinational one-hot grant between fetch and load/store requests.
// last_grant names the owner that wins when both request in the same cycle.
module arb_grant
   import mem_arbiter_pkg::*;
(
   input  logic       instr_req,
   input  logic       data_req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (instr_req && data_req) begin
         if (last_grant == OWNER_D) grant[GRANT_D] = 1'b1;
         else                       grant[GRANT_I] = 1'b1;
      end else begin
         grant[GRANT_I] = instr_req;
         grant[GRANT_D] = data_req;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and load/store.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate tie priority; default is data over instruction.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
) (
   input  logic                   clk,
   input  logic                   res,
   input  logic                   instr_req,
   input  logic [AddrWidth-1:0]   instr_addr,
   output logic                   instr_valid,
   output logic [DataWidth-1:0]   instr_read,
   input  logic                   data_req,
   input  logic                   data_we,
   input  logic [AddrWidth-1:0]   data_addr,
   input  logic [DataWidth-1:0]   data_wdata,
   input  logic [DataWidth/8-1:0] data_be,
   output logic                   data_valid,
   output logic [DataWidth-1:0]   data_rdata,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [AddrWidth-1:0]   mem_addr,
   output logic [DataWidth-1:0]   mem_wdata,
   output logic [DataWidth/8-1:0] mem_be,
   input  logic                   mem_ack,
   input  logic [DataWidth-1:0]   mem_rdata
);

   mem_arb_state_t         state_q, state_d;
   logic                   mem_req_q, mem_req_d;
   logic                   mem_we_q, mem_we_d;
   logic [AddrWidth-1:0]   mem_addr_q, mem_addr_d;
   logic [DataWidth-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DataWidth/8-1:0] mem_be_q, mem_be_d;
   logic                   instr_valid_q, instr_valid_d;
   logic                   data_valid_q, data_valid_d;
   logic [DataWidth-1:0]   instr_read_q, instr_read_d;
   logic [DataWidth-1:0]   data_rdata_q, data_rdata_d;
   logic [1:0]             grant;
   mem_arb_owner_t         tie_owner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   mem_arb_owner_t last_grant_q, last_grant_d;

   always_ff @(posedge clk or posedge res) begin
      if (res) last_grant_q <= OWNER_I;
      else     last_grant_q <= last_grant_d;
   end

   // Tie priority flips on every grant so contention alternates I, D, I, D
   always_comb begin
      last_grant_d = last_grant_q;
      if (state_q == IDLE && grant != 2'b00) last_grant_d = other_owner(last_grant_q);
   end

   assign tie_owner = last_grant_q;
`else
   assign tie_owner = OWNER_D;
`endif

   arb_grant u_arb_grant (
      .instr_req  (instr_req),
      .data_req   (data_req),
      .last_grant (tie_owner),
      .grant      (grant)
   );

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q       <= IDLE;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_be_q      <= '0;
         instr_valid_q <= 1'b0;
         data_valid_q  <= 1'b0;
         instr_read_q  <= '0;
         data_rdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_be_q      <= mem_be_d;
         instr_valid_q <= instr_valid_d;
         data_valid_q  <= data_valid_d;
         instr_read_q  <= instr_read_d;
         data_rdata_q  <= data_rdata_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d       = state_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_be_d      = mem_be_q;
      instr_valid_d = 1'b0;
      data_valid_d  = 1'b0;
      instr_read_d  = instr_read_q;
      data_rdata_d  = data_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (grant[GRANT_D]) begin
               state_d     = BUSY_D;
               mem_req_d   = 1'b1;
               mem_we_d    = data_we;
               mem_addr_d  = data_addr;
               mem_wdata_d = data_wdata;
               mem_be_d    = data_be;
            end else if (grant[GRANT_I]) begin
               state_d     = BUSY_I;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = instr_addr;
               mem_wdata_d = '0;
               mem_be_d    = '0;
            end
         end
         BUSY_I: begin
            if (mem_ack) begin
               state_d       = RESP;
               mem_req_d     = 1'b0;
               instr_read_d  = mem_rdata;
               instr_valid_d = 1'b1;
            end
         end
         BUSY_D: begin
            if (mem_ack) begin
               state_d      = RESP;
               mem_req_d    = 1'b0;
               data_rdata_d = mem_we_q ? '0 : mem_rdata;
               data_valid_d = 1'b1;
            end
         end
         // Requests are not sampled here: the owner drops req after seeing valid
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_be      = mem_be_q;
   assign instr_valid = instr_valid_q;
   assign instr_read  = instr_read_q;
   assign data_valid  = data_valid_q;
   assign data_rdata  = data_rdata_q;

`ifndef SYNTHESIS
   a_instr_hold: assert property (@(posedge clk) disable iff (res)
      (state_q == BUSY_I || (state_q == RESP && instr_valid_q)) |-> instr_req)
      else $error("instr_req dropped before instr_valid");

   a_data_hold: assert property (@(posedge clk) disable iff (res)
      (state_q == BUSY_D || (state_q == RESP && data_valid_q)) |-> data_req)
      else $error("data_req dropped before data_valid");
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model, memory responder,
// per-cycle compare on the falling edge and directed literal checks.
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        res;
   logic        instr_req, instr_valid;
   logic [31:0] instr_addr, instr_read;
   logic        data_req, data_we, data_valid;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_be;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk         (clk),
      .res         (res),
      .instr_req   (instr_req),
      .instr_addr  (instr_addr),
      .instr_valid (instr_valid),
      .instr_read  (instr_read),
      .data_req    (data_req),
      .data_we     (data_we),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_be     (data_be),
      .data_valid  (data_valid),
      .data_rdata  (data_rdata),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_be      (mem_be),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rdata_for(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'h0051_0113;
      return a ^ 32'h5A5A_0000;
   endfunction

   // ---------------- memory responder ----------------
   int ack_wait   = 0;
   bit ack_auto   = 1'b1;
   int stray_cnt  = 0;
   int stray_seen = 0;
   int ack_cnt    = 0;

   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (stray_cnt != stray_seen) begin
            stray_seen = stray_cnt;
            mem_ack    = 1'b1;
            mem_rdata  = 32'hBAD0_BAD0;
         end else if (ack_auto && mem_req) begin
            if (ack_cnt >= ack_wait) begin
               mem_ack   = 1'b1;
               mem_rdata = rdata_for(mem_addr);
               ack_cnt   = 0;
            end else begin
               ack_cnt++;
            end
         end else begin
            ack_cnt = 0;
         end
      end
   end

   // ---------------- transaction-level model ----------------
   localparam int NONE  = 0;
   localparam int OWN_I = 1;
   localparam int OWN_D = 2;

   int          m_owner = NONE;   // who the memory is currently serving
   bit          m_reply = 1'b0;   // one response cycle, requests ignored
   bit          m_tie_d = 1'b0;   // round robin: next tie goes to data
   int          m_win;
   int          grant_log[$];
   logic        exp_mem_req = 0, exp_we = 0, exp_iv = 0, exp_dv = 0;
   logic [31:0] exp_addr = 0, exp_wdata = 0, exp_ir = 0, exp_dr = 0;
   logic [3:0]  exp_be = 0;

   always @(posedge clk or posedge res) begin
      if (res) begin
         m_owner = NONE; m_reply = 1'b0; m_tie_d = 1'b0;
         exp_mem_req = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_be = 0;
         exp_iv = 0; exp_dv = 0; exp_ir = 0; exp_dr = 0;
      end else begin
         exp_iv = 0;
         exp_dv = 0;
         if (m_reply) begin
            m_reply = 1'b0;
         end else if (m_owner != NONE) begin
            if (mem_ack) begin
               exp_mem_req = 0;
               if (m_owner == OWN_I) begin
                  exp_iv = 1; exp_ir = mem_rdata;
               end else begin
                  exp_dv = 1; exp_dr = exp_we ? 32'h0 : mem_rdata;
               end
               m_owner = NONE;
               m_reply = 1'b1;
            end
         end else if (instr_req || data_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (instr_req && data_req) m_win = m_tie_d ? OWN_D : OWN_I;
            else                       m_win = data_req ? OWN_D : OWN_I;
            m_tie_d = !m_tie_d;
`else
            m_win = data_req ? OWN_D : OWN_I;
`endif
            grant_log.push_back(m_win);
            m_owner     = m_win;
            exp_mem_req = 1;
            if (m_win == OWN_D) begin
               exp_we = data_we; exp_addr = data_addr; exp_wdata = data_wdata; exp_be = data_be;
            end else begin
               exp_we = 0; exp_addr = instr_addr;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      check("mem_req", mem_req, exp_mem_req);
      check("instr_valid", instr_valid, exp_iv);
      check("data_valid", data_valid, exp_dv);
      check("instr_read", instr_read, exp_ir);
      check("data_rdata", data_rdata, exp_dr);
      if (exp_mem_req || res) begin
         check("mem_we", mem_we, exp_we);
         check("mem_addr", mem_addr, exp_addr);
      end
      if (res || (exp_mem_req && m_owner == OWN_D)) begin
         check("mem_wdata", mem_wdata, exp_wdata);
         check("mem_be", mem_be, exp_be);
      end
   end

   // ---------------- requester driver ----------------
   // Requests are raised by the caller in cycle 0; each owner drops req the cycle after its valid.
   task automatic serve(output int t_mreq, output int n_mreq, output int t_valid,
                        output int n_valid, output logic [31:0] rd,
                        output logic [31:0] a_first, output logic we_first);
      bit drop_i = 0, drop_d = 0;
      int t = 0, quiet = 0;
      t_mreq = -1; n_mreq = 0; t_valid = -1; n_valid = 0; rd = '0; a_first = '0; we_first = 1'b0;
      while (quiet < 3 && t < 60) begin
         @(posedge clk);
         #1;
         t++;
         if (drop_i) begin instr_req = 1'b0; drop_i = 0; end
         if (drop_d) begin data_req  = 1'b0; drop_d = 0; end
         if (mem_req) begin
            n_mreq++;
            if (t_mreq < 0) begin t_mreq = t; a_first = mem_addr; we_first = mem_we; end
         end
         if (instr_valid || data_valid) begin
            n_valid++;
            if (t_valid < 0) begin t_valid = t; rd = instr_valid ? instr_read : data_rdata; end
            if (instr_valid) drop_i = 1;
            if (data_valid)  drop_d = 1;
         end
         quiet = (instr_req || data_req) ? 0 : quiet + 1;
      end
      if (quiet < 3) check("serve_timeout", 1, 0);
   endtask

   task automatic do_reset(input int cycles);
      res = 1'b1;
      repeat (cycles) @(posedge clk);
      #1 res = 1'b0;
   endtask

   int          t_mreq, n_mreq, t_valid, n_valid, base, n_pulse;
   logic [31:0] rd, a_first;
   logic        we_first;
   int          exp_order[8];

   initial begin
      instr_req = 0; instr_addr = 0; data_req = 0; data_we = 0;
      data_addr = 0; data_wdata = 0; data_be = 0;
      res = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_instr_valid", instr_valid, 0);
      check("rst_data_rdata", data_rdata, 0);
      res = 1'b0;

      // single fetch, ack in cycle 3
      ack_wait = 2;
      @(posedge clk); #1;
      instr_addr = 32'h0000_0010; instr_req = 1'b1;
      serve(t_mreq, n_mreq, t_valid, n_valid, rd, a_first, we_first);
      check("fetch_mreq_cycle", t_mreq, 1);
      check("fetch_mem_addr", a_first, 32'h10);
      check("fetch_mem_we", we_first, 0);
      check("fetch_mreq_cycles", n_mreq, 3);
      check("fetch_valid_cycle", t_valid, 4);
      check("fetch_valid_pulses", n_valid, 1);
      check("fetch_read", rd, 32'h0051_0113);
      check("fetch_read_hold", instr_read, 32'h0051_0113);

      // load, zero-wait memory
      ack_wait = 0;
      @(posedge clk); #1;
      data_addr = 32'h200; data_we = 1'b0; data_req = 1'b1;
      serve(t_mreq, n_mreq, t_valid, n_valid, rd, a_first, we_first);
      check("load_valid_cycle", t_valid, 2);
      check("load_rdata", rd, 32'h5A5A_0200);
      check("load_rdata_hold", data_rdata, 32'h5A5A_0200);

      // store
      ack_wait = 1;
      @(posedge clk); #1;
      data_addr = 32'h100; data_we = 1'b1; data_wdata = 32'hDEAD_BEEF; data_be = 4'hF; data_req = 1'b1;
      serve(t_mreq, n_mreq, t_valid, n_valid, rd, a_first, we_first);
      check("store_mem_addr", a_first, 32'h100);
      check("store_mem_we", we_first, 1);
      check("store_mem_wdata_held", mem_wdata, 32'hDEAD_BEEF);
      check("store_mem_be_held", mem_be, 4'hF);
      check("store_valid_cycle", t_valid, 3);
      check("store_valid_pulses", n_valid, 1);
      check("store_rdata_zero", rd, 0);
      data_we = 1'b0;

      // contention x4 from a fresh reset
      do_reset(2);
      base = grant_log.size();
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         instr_addr = 32'h20 + 32'(k * 4); data_addr = 32'h300 + 32'(k * 4);
         instr_req = 1'b1; data_req = 1'b1;
         serve(t_mreq, n_mreq, t_valid, n_valid, rd, a_first, we_first);
         check("contend_valid_pulses", n_valid, 2);
      end
      for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         exp_order[i] = (i % 2 == 0) ? OWN_I : OWN_D;
`else
         exp_order[i] = (i % 2 == 0) ? OWN_D : OWN_I;
`endif
      end
      check("contend_grant_count", grant_log.size() - base, 8);
      for (int i = 0; i < 8; i++)
         if (base + i < grant_log.size()) check("contend_order", grant_log[base + i], exp_order[i]);

      // reset during BUSY_I, then a stray ack after release
      ack_auto = 1'b0;
      @(posedge clk); #1;
      instr_addr = 32'h80; instr_req = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("mid_busy_mem_req", mem_req, 1);
      res = 1'b1; instr_req = 1'b0;
      @(posedge clk); #1;
      res = 1'b0;
      @(posedge clk); #2;
      stray_cnt++;
      n_pulse = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (instr_valid || data_valid || mem_req) n_pulse++;
      end
      check("stray_no_activity", n_pulse, 0);
      check("stray_instr_read", instr_read, 0);
      check("stray_mem_addr", mem_addr, 0);
      ack_auto = 1'b1;

      // zero-wait fetch: req stays high through RESP
      ack_wait = 0;
      @(posedge clk); #1;
      instr_addr = 32'h40; instr_req = 1'b1;
      serve(t_mreq, n_mreq, t_valid, n_valid, rd, a_first, we_first);
      check("zw_mreq_cycle", t_mreq, 1);
      check("zw_valid_cycle", t_valid, 2);
      check("zw_single_mreq", n_mreq, 1);
      check("zw_read", rd, 32'h5A5A_0040);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
